// File: rtl/count_seq_monitor.sv
// rtl/count_seq_monitor.sv - sequence checker for a bounded 0..MAX up-counter
//
// Watches a bounded up-counter that counts 0..MAX and then holds at MAX.
// Each valid sample is checked against the previous legal value:
//   - hold at the same value
//   - step by +1
//   - restart at 0
// Any other value is an error. Entries into HOLD are counted as
// terminal-count events.
//
// Optional build macro: COUNT_MON_ERR_CLR_EN
//   When defined, an err_clr input is added. It releases the FAULT state.
//   When undefined, FAULT is left only by reset.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   in_valid   count_in is sampled only when high
//   count_in   value from the upstream counter (CW bits)
//   err_clr    FAULT release (only with COUNT_MON_ERR_CLR_EN)
//   state      IDLE=0, RUN=1, HOLD=2, FAULT=3
//   at_max     high while in HOLD
//   tc_pulse   one-cycle pulse on each entry into HOLD
//   tc_events  saturating count of HOLD entries (EW bits)
//   err        sticky error, high while in FAULT
module count_seq_monitor #(
    parameter int CW  = 3,
    parameter int MAX = 3,
    parameter int EW  = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [CW-1:0] count_in,
`ifdef COUNT_MON_ERR_CLR_EN
    input  logic          err_clr,
`endif
    output logic [1:0]    state,
    output logic          at_max,
    output logic          tc_pulse,
    output logic [EW-1:0] tc_events,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [CW-1:0] MAX_V  = CW'(MAX);
    localparam logic [EW-1:0] EV_SAT = '1;

    state_t        st_q;
    state_t        st_nxt;
    logic [CW-1:0] prev;
    logic [CW-1:0] prev_nxt;
    logic [CW:0]   prev_inc;
    logic          is_oor;
    logic          is_zero;
    logic          is_same;
    logic          is_step;
    logic          is_max;
    logic          enter_hold;

    // prev+1 is formed one bit wider so an all-ones prev cannot alias to 0.
    assign prev_inc = {1'b0, prev} + {{CW{1'b0}}, 1'b1};

    assign is_oor  = count_in > MAX_V;
    assign is_zero = count_in == '0;
    assign is_same = count_in == prev;
    assign is_step = {1'b0, count_in} == prev_inc;
    assign is_max  = count_in == MAX_V;

    // Out-of-range is tested first in every state, so it overrides
    // the restart, same and step classifications.
    always_comb begin
        st_nxt   = st_q;
        prev_nxt = prev;
        case (st_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_oor) begin
                        st_nxt = FAULT;
                    end else begin
                        prev_nxt = count_in;
                        st_nxt   = is_max ? HOLD : RUN;
                    end
                end
            end
            RUN: begin
                if (in_valid) begin
                    if (is_oor) begin
                        st_nxt = FAULT;
                    end else if (is_zero || is_same || is_step) begin
                        prev_nxt = count_in;
                        st_nxt   = is_max ? HOLD : RUN;
                    end else begin
                        st_nxt = FAULT;
                    end
                end
            end
            HOLD: begin
                // MAX+1 is never legal here, so the counter cannot wrap past MAX.
                if (in_valid) begin
                    if (is_oor) begin
                        st_nxt = FAULT;
                    end else if (is_max) begin
                        st_nxt = HOLD;
                    end else if (is_zero) begin
                        prev_nxt = '0;
                        st_nxt   = RUN;
                    end else begin
                        st_nxt = FAULT;
                    end
                end
            end
            FAULT: begin
`ifdef COUNT_MON_ERR_CLR_EN
                if (err_clr) begin
                    st_nxt   = IDLE;
                    prev_nxt = '0;
                end
`endif
            end
            default: st_nxt = FAULT;
        endcase
    end

    assign enter_hold = (st_nxt == HOLD) && (st_q != HOLD);

    // The flag outputs are registered from the next state, so they always
    // agree with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q      <= IDLE;
            prev      <= '0;
            at_max    <= 1'b0;
            tc_pulse  <= 1'b0;
            tc_events <= '0;
            err       <= 1'b0;
        end else begin
            st_q     <= st_nxt;
            prev     <= prev_nxt;
            at_max   <= st_nxt == HOLD;
            err      <= st_nxt == FAULT;
            tc_pulse <= enter_hold;
            if (enter_hold && (tc_events != EV_SAT)) begin
                tc_events <= tc_events + 1'b1;
            end
        end
    end

    assign state = st_q;

endmodule
